// File: rtl/pwm_pkg.sv
// Shared types and constants for the unipolar H-bridge PWM modulator.
package pwm_pkg;

  localparam int unsigned MOD_W      = 12;
  localparam int unsigned MOD_OFFSET = 2048;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned OPND_W     = 13;
  localparam int unsigned PROD_W     = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pwm_state_e;

  localparam logic [1:0] BOTH_OFF = 2'b00;
  localparam logic [1:0] RIGHT_ON = 2'b01;
  localparam logic [1:0] LEFT_ON  = 2'b10;
  localparam logic [1:0] BOTH_ON  = 2'b11;

  // Fold the asymmetric -2048 onto -2047 so the reference range is symmetric.
  function automatic logic [MOD_W-1:0] clamp_ref(input logic [MOD_W-1:0] m);
    logic [MOD_W-1:0] min_neg;
    min_neg = {1'b1, {(MOD_W-1){1'b0}}};
    return (m == min_neg) ? (min_neg | MOD_W'(1)) : m;
  endfunction

endpackage

// File: rtl/pwm_mod_gen_carrier.sv
// Phase-loadable triangular carrier with registered zero pulse.
// PWM_DOUBLE_UPDATE_EN: the carrier peak is also a reference update point.
module pwm_carrier
  import pwm_pkg::*;
#(
  parameter int unsigned CARRIER_MAX = 1250,
  parameter int unsigned PHASE       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             run,
  input  logic             sync,
  output logic [CNT_W-1:0] cnt,
  output logic             upd_pt_c,
  output logic             carrier_zero
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(CARRIER_MAX);
  localparam logic [CNT_W-1:0] PHASE_C = CNT_W'(PHASE);

  logic up;
  logic at_zero_c;

  assign at_zero_c = (cnt == '0);

`ifdef PWM_DOUBLE_UPDATE_EN
  assign upd_pt_c = at_zero_c | (cnt == MAX_C);
`else
  assign upd_pt_c = at_zero_c;
`endif

  // Triangle counter; turns at both ends without dwelling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= PHASE_C;
      up  <= 1'b1;
    end else if (hold || (run && sync)) begin
      cnt <= PHASE_C;
      up  <= 1'b1;
    end else if (run) begin
      if (up) begin
        if (cnt >= MAX_C) begin
          cnt <= MAX_C - CNT_W'(1);
          up  <= 1'b0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        if (cnt == '0) begin
          cnt <= CNT_W'(1);
          up  <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_zero <= 1'b0;
    end else begin
      carrier_zero <= run && at_zero_c;
    end
  end

endmodule

// File: rtl/pwm_mod_gen.sv
// Unipolar carrier-based PWM modulator for one H-bridge unit with double-buffered reference.
// PWM_DOUBLE_UPDATE_EN: reference may also update at the carrier peak.
module pwm_mod_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CARRIER_MAX = 1250,
  parameter int unsigned PHASE       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop,
  input  logic             err_unit,
  input  logic             sync_in,
  input  logic             mod_valid,
  input  logic [MOD_W-1:0] mod_ref,
  output logic             mod_ready,
  output logic [1:0]       igbt_control,
  output logic             carrier_zero,
  output logic             running
);

  pwm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt;
  logic              upd_pt_c;
  logic              hold_c, run_c;
  logic              accept_c, take_c;
  logic [MOD_W-1:0]  act_ref, pend_ref;
  logic [OPND_W-1:0] opnd_l, opnd_r;
  logic [PROD_W-1:0] prod_l, prod_r;
  logic [MOD_W-1:0]  thr_l, thr_r;
  logic [1:0]        cmp_c;
  logic [1:0]        igbt_d;
  logic              running_d;

  assign hold_c = (state_q == IDLE);
  assign run_c  = (state_q == RUN);

  pwm_carrier #(
    .CARRIER_MAX (CARRIER_MAX),
    .PHASE       (PHASE)
  ) u_carrier (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold_c),
    .run          (run_c),
    .sync         (sync_in),
    .cnt          (cnt),
    .upd_pt_c     (upd_pt_c),
    .carrier_zero (carrier_zero)
  );

  // Offset-binary (2048+m) is the sign-inverted two's complement pattern.
  assign opnd_l = {1'b0, ~act_ref[MOD_W-1], act_ref[MOD_W-2:0]};
  assign opnd_r = OPND_W'(2 * MOD_OFFSET) - opnd_l;
  assign prod_l = PROD_W'(opnd_l) * PROD_W'(CARRIER_MAX);
  assign prod_r = PROD_W'(opnd_r) * PROD_W'(CARRIER_MAX);
  assign thr_l  = MOD_W'(prod_l >> MOD_W);
  assign thr_r  = MOD_W'(prod_r >> MOD_W);

  assign cmp_c = ((MOD_W'(cnt) < thr_l) ? LEFT_ON  : BOTH_OFF) |
                 ((MOD_W'(cnt) < thr_r) ? RIGHT_ON : BOTH_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output decode; fault outranks stop.
  always_comb begin
    state_d   = state_q;
    igbt_d    = BOTH_OFF;
    running_d = 1'b0;
    unique case (state_q)
      IDLE:    if (start_stop && !err_unit) state_d = RUN;
      RUN: begin
        if (err_unit)         state_d = FAULT;
        else if (!start_stop) state_d = IDLE;
      end
      FAULT:   if (!start_stop && !err_unit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (run_c && (state_d == RUN)) igbt_d = cmp_c;
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      igbt_control <= BOTH_OFF;
      running      <= 1'b0;
    end else begin
      igbt_control <= igbt_d;
      running      <= running_d;
    end
  end

  // Pending buffer is full exactly when mod_ready is low.
  assign accept_c = mod_valid && mod_ready;
  assign take_c   = !mod_ready && (!run_c || upd_pt_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_ref   <= '0;
      pend_ref  <= '0;
      mod_ready <= 1'b1;
    end else if (accept_c) begin
      pend_ref  <= clamp_ref(mod_ref);
      mod_ready <= 1'b0;
    end else if (take_c) begin
      act_ref   <= pend_ref;
      mod_ready <= 1'b1;
    end
  end

endmodule
